// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO unit: ALU funct codes, sequencer state encoding and
// the multiplier control defaults.
package hilo_pkg;

  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;

  localparam int unsigned MUL_CYCLES_DEF = 32;
  localparam logic [5:0]  IDLE_CTRL_DEF  = 6'h3F;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StCapt = 2'd2,
    StDone = 2'd3
  } hilo_state_e;

endpackage

// File: rtl/hilo_if.sv
// Bus between the datapath/multiplier side (master) and the HI/LO unit (slave).
interface hilo_if;
  logic [5:0]  signal;
  logic [31:0] dataA;
  logic [63:0] MulAns;
  logic [5:0]  mulCtrl;
  logic [31:0] HiLoOut;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output signal, dataA, MulAns,
    input  mulCtrl, HiLoOut, busy, done, stall
  );

  modport slave (
    input  signal, dataA, MulAns,
    output mulCtrl, HiLoOut, busy, done, stall
  );
endinterface

// File: rtl/hilo_seq_fsm.sv
// Multiply sequencer: starts the multiplier, waits out its latency and flags the capture cycle.
module hilo_seq_fsm
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter logic [5:0]  IDLE_CTRL  = IDLE_CTRL_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  output logic [5:0] mul_ctrl_o,
  output logic       busy_o,
  output logic       capt_o,
  output logic       done_o
);

  localparam logic [5:0] CntLast = 6'(MUL_CYCLES - 1);

  hilo_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  mul_ctrl_q, mul_ctrl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      mul_ctrl_q <= IDLE_CTRL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_ctrl_q <= mul_ctrl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_ctrl_d = mul_ctrl_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StRun;
          cnt_d      = 6'd0;
          mul_ctrl_d = 6'd0;
        end
      end
      StRun: begin
        // A MULTU arriving here is ignored: only IDLE looks at start_i.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CntLast) begin
          state_d = StCapt;
        end
      end
      StCapt: begin
        mul_ctrl_d = IDLE_CTRL;
        state_d    = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mul_ctrl_o = mul_ctrl_q;
  assign busy_o     = (state_q == StRun) || (state_q == StCapt);
  assign capt_o     = (state_q == StCapt);
  assign done_o     = (state_q == StDone);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file with MULTU sequencing and MFHI/MFLO/MTHI/MTLO service.
// Define HILO_STALL_EN to stall HI/LO accesses and MULTU while a multiply is in flight.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter logic [5:0]  IDLE_CTRL  = IDLE_CTRL_DEF
) (
  input  logic   clk,
  input  logic   reset,
  hilo_if.slave  bus
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        start;
  logic        capt;
  logic        busy;
  logic        done;
  logic [5:0]  mul_ctrl;

  assign start = (bus.signal == FN_MULTU);

  hilo_seq_fsm #(
    .MUL_CYCLES (MUL_CYCLES),
    .IDLE_CTRL  (IDLE_CTRL)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .mul_ctrl_o (mul_ctrl),
    .busy_o     (busy),
    .capt_o     (capt),
    .done_o     (done)
  );

  // Capture is applied last so it overrides a coincident MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.signal == FN_MTHI) hi_d = bus.dataA;
    if (bus.signal == FN_MTLO) lo_d = bus.dataA;
    if (capt) begin
      hi_d = bus.MulAns[63:32];
      lo_d = bus.MulAns[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    bus.HiLoOut = 32'd0;
    if (bus.signal == FN_MFHI) bus.HiLoOut = hi_q;
    if (bus.signal == FN_MFLO) bus.HiLoOut = lo_q;
  end

  assign bus.mulCtrl = mul_ctrl;
  assign bus.busy    = busy;
  assign bus.done    = done;

`ifdef HILO_STALL_EN
  assign bus.stall = busy && (bus.signal inside {FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO, FN_MULTU});
`else
  assign bus.stall = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit with a behavioural 32-step shift-add multiplier model.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int unsigned MulCycles = 32;
`ifdef HILO_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk;
  logic reset;
  hilo_if bus ();

  hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  int done_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] op_a, op_b;
  logic [63:0] mul_acc;
  int          mul_i;
  logic [31:0] hi_m, lo_m;
  logic [63:0] pend;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: cleared while its control is non-zero, one partial product per edge.
  always @(posedge clk) begin
    if (bus.mulCtrl != 6'd0) begin
      mul_acc <= 64'd0;
      mul_i   <= 0;
    end else if (mul_i < 32) begin
      if (op_b[mul_i]) mul_acc <= mul_acc + ({32'd0, op_a} << mul_i);
      mul_i <= mul_i + 1;
    end
  end
  assign bus.MulAns = mul_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: done timing/busy length and read data are popped from the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
          chk("busy_len", 64'(busy_run), 64'(MulCycles + 1));
        end
        busy_run = 0;
      end
      if (bus.signal == FN_MFHI || bus.signal == FN_MFLO) begin
        if (rd_q.size() == 0) chk("unexpected_read", 64'(bus.HiLoOut), 64'hFFFF_FFFF_0000_0000);
        else chk("read", 64'(bus.HiLoOut), 64'(rd_q.pop_front()));
      end
    end
  end

  // One instruction per cycle: drive after the edge, check stall, hold through the next edge.
  task automatic op(input logic [5:0] sig, input logic [31:0] data, input bit exp_stall);
    bus.signal = sig;
    bus.dataA  = data;
    #1;
    chk("stall", 64'(bus.stall), 64'(exp_stall));
    @(posedge clk);
    #1;
    bus.signal = 6'd0;
    bus.dataA  = 32'd0;
  endtask

  task automatic idle(input int n, input bit busy_now);
    for (int i = 0; i < n; i++) op(6'd0, 32'd0, 1'b0 && busy_now);
  endtask

  task automatic read_hi(input bit busy_now);
    rd_q.push_back(hi_m);
    op(FN_MFHI, 32'd0, StallEn && busy_now);
  endtask

  task automatic read_lo(input bit busy_now);
    rd_q.push_back(lo_m);
    op(FN_MFLO, 32'd0, StallEn && busy_now);
  endtask

  task automatic mt_hi(input logic [31:0] d);
    hi_m = d;
    op(FN_MTHI, d, 1'b0);
  endtask

  task automatic mt_lo(input logic [31:0] d);
    lo_m = d;
    op(FN_MTLO, d, 1'b0);
  endtask

  task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
    op_a = a;
    op_b = b;
    pend = {32'd0, a} * {32'd0, b};
    done_q.push_back(cyc + MulCycles + 2);
    op(FN_MULTU, 32'd0, 1'b0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() != 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 64'(done_q.size()), 64'd0);
    done_q.delete();
    hi_m = pend[63:32];
    lo_m = pend[31:0];
  endtask

  task automatic mult(input logic [31:0] a, input logic [31:0] b);
    start_mult(a, b);
    wait_done();
  endtask

  initial begin
    reset      = 1'b1;
    bus.signal = 6'd0;
    bus.dataA  = 32'd0;
    op_a = 32'd0;
    op_b = 32'd0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    pend = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mulctrl", 64'(bus.mulCtrl), 64'h3F);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_hilo_out", 64'(bus.HiLoOut), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    busy_run = 0;
    read_hi(1'b0);
    read_lo(1'b0);

    // Small product, then all-ones operands.
    mult(32'd3, 32'd5);
    read_lo(1'b0);
    read_hi(1'b0);
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hi(1'b0);
    read_lo(1'b0);

    // Direct writes while idle.
    mt_hi(32'hDEAD_BEEF);
    mt_lo(32'h1234_5678);
    read_hi(1'b0);
    read_lo(1'b0);

    // Reset ten cycles into RUN.
    start_mult(32'h0001_0003, 32'h0002_0007);
    idle(10, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_mulctrl", 64'(bus.mulCtrl), 64'h3F);
    bus.signal = FN_MFHI;
    #1;
    chk("midrst_hi", 64'(bus.HiLoOut), 64'd0);
    bus.signal = FN_MFLO;
    #1;
    chk("midrst_lo", 64'(bus.HiLoOut), 64'd0);
    bus.signal = 6'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_q.delete();
    busy_run = 0;
    hi_m = 32'd0;
    lo_m = 32'd0;
    read_hi(1'b0);
    read_lo(1'b0);
    mult(32'd7, 32'd6);
    read_lo(1'b0);

    // Stale read of LO during RUN; an MTHI in RUN is lost to the capture.
    mt_lo(32'd9);
    start_mult(32'h0000_1000, 32'h0000_0100);
    idle(5, 1'b1);
    read_lo(1'b1);
    op(FN_MTHI, 32'h1111_1111, StallEn);
    wait_done();
    read_hi(1'b0);
    read_lo(1'b0);

    // Second MULTU at cnt=3 is ignored; MTLO on the capture edge loses to the product.
    start_mult(32'hCAFE_F00D, 32'h8765_4321);
    idle(3, 1'b1);
    op(FN_MULTU, 32'd0, StallEn);
    idle(28, 1'b1);
    op(FN_MTLO, 32'hAAAA_5555, StallEn);
    wait_done();
    read_lo(1'b0);
    read_hi(1'b0);

    // Random products and writes.
    for (int i = 0; i < 6; i++) begin
      mult($urandom, (i == 0) ? 32'd0 : $urandom);
      read_hi(1'b0);
      read_lo(1'b0);
      if ($urandom_range(1, 0) == 1) mt_hi($urandom);
      else mt_lo($urandom);
      read_hi(1'b0);
      read_lo(1'b0);
    end

    idle(3, 1'b0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
